vector_list_sequencer: RTL and testbench

VECTOR_LIST_SEQUENCER -- requirements
Module: vector_list_sequencer

---
 rtl/vector_list_sequencer.sv | 171 +++++++++++++++++
 tb/tb_vector_list_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_list_sequencer.sv
// Walks a vector display list in memory and issues one draw command per POS/LINE entry.
// Define VECTOR_SEQ_CLAMP_EN to clamp list coordinates to [FRAME_MIN, FRAME_MAX].
module vector_list_sequencer #(
   parameter int OUT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int FRAME_MIN  = 0,
   parameter int FRAME_MAX  = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_start,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic                     mem_rd,
   input  logic [2+2*OUT_WIDTH-1:0] mem_data,
   input  logic                     busy,
   output logic                     go,
   output logic [OUT_WIDTH-1:0]     start_x,
   output logic [OUT_WIDTH-1:0]     start_y,
   output logic [OUT_WIDTH-1:0]     end_x,
   output logic [OUT_WIDTH-1:0]     end_y,
   output logic                     active,
   output logic                     frame_done,
   output logic                     frame_overrun
);

   localparam int ENTRY_W = 2 + 2*OUT_WIDTH;
   localparam logic [OUT_WIDTH-1:0] COORD_MIN = OUT_WIDTH'(FRAME_MIN);
   localparam logic [OUT_WIDTH-1:0] COORD_MAX = OUT_WIDTH'(FRAME_MAX);
`ifdef VECTOR_SEQ_CLAMP_EN
   localparam bit CLAMP_ON = 1'b1;
`else
   localparam bit CLAMP_ON = 1'b0;
`endif

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_POS  = 2'b01;
   localparam logic [1:0] OP_LINE = 2'b10;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_t;

   function automatic logic [OUT_WIDTH-1:0] fit(input logic [OUT_WIDTH-1:0] v);
      int iv;
      iv = int'(v);
      if (CLAMP_ON && iv < FRAME_MIN)      fit = COORD_MIN;
      else if (CLAMP_ON && iv > FRAME_MAX) fit = COORD_MAX;
      else                                 fit = v;
   endfunction

   state_t                  state, state_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic                    rd_d, go_d, active_d, done_d, overrun_d;
   logic [OUT_WIDTH-1:0]    sx_d, sy_d, ex_d, ey_d;
   logic [OUT_WIDTH-1:0]    cur_x, cur_y, cx_d, cy_d;
   logic [1:0]              op;
   logic [OUT_WIDTH-1:0]    pos_x, pos_y;
   logic                    last_addr;

   assign op        = mem_data[ENTRY_W-1 -: 2];
   assign pos_x     = fit(mem_data[2*OUT_WIDTH-1 -: OUT_WIDTH]);
   assign pos_y     = fit(mem_data[OUT_WIDTH-1:0]);
   assign last_addr = (mem_addr == {ADDR_WIDTH{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         mem_addr      <= '0;
         mem_rd        <= 1'b0;
         go            <= 1'b0;
         start_x       <= COORD_MIN;
         start_y       <= COORD_MIN;
         end_x         <= COORD_MIN;
         end_y         <= COORD_MIN;
         cur_x         <= COORD_MIN;
         cur_y         <= COORD_MIN;
         active        <= 1'b0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         state         <= state_d;
         mem_addr      <= addr_d;
         mem_rd        <= rd_d;
         go            <= go_d;
         start_x       <= sx_d;
         start_y       <= sy_d;
         end_x         <= ex_d;
         end_y         <= ey_d;
         cur_x         <= cx_d;
         cur_y         <= cy_d;
         active        <= active_d;
         frame_done    <= done_d;
         frame_overrun <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state;
      addr_d    = mem_addr;
      rd_d      = 1'b0;
      go_d      = 1'b0;
      sx_d      = start_x;
      sy_d      = start_y;
      ex_d      = end_x;
      ey_d      = end_y;
      cx_d      = cur_x;
      cy_d      = cur_y;
      active_d  = active;
      overrun_d = frame_start & active;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_d  = FETCH;
               addr_d   = '0;
               rd_d     = 1'b1;
               active_d = 1'b1;
               cx_d     = COORD_MIN;
               cy_d     = COORD_MIN;
            end
         end
         FETCH: state_d = DECODE;
         // Read data for the strobe issued in FETCH is valid during this state
         DECODE: begin
            case (op)
               OP_NOP: begin
                  if (last_addr) state_d = DONE;
                  else begin
                     addr_d  = mem_addr + ADDR_WIDTH'(1);
                     rd_d    = 1'b1;
                     state_d = FETCH;
                  end
               end
               OP_POS: begin
                  sx_d = pos_x;  sy_d = pos_y;
                  ex_d = pos_x;  ey_d = pos_y;
                  cx_d = pos_x;  cy_d = pos_y;
                  state_d = ISSUE;
               end
               OP_LINE: begin
                  sx_d = cur_x;  sy_d = cur_y;
                  ex_d = pos_x;  ey_d = pos_y;
                  cx_d = pos_x;  cy_d = pos_y;
                  state_d = ISSUE;
               end
               default: state_d = DONE;
            endcase
         end
         ISSUE: begin
            go_d    = 1'b1;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: if (busy) state_d = WAIT_DONE;
         // The last address ends the frame instead of wrapping to entry 0
         WAIT_DONE: begin
            if (!busy) begin
               if (last_addr) state_d = DONE;
               else begin
                  addr_d  = mem_addr + ADDR_WIDTH'(1);
                  rd_d    = 1'b1;
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            active_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
   end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Directed bench for vector_list_sequencer (ADDR_WIDTH=2, FRAME_MAX=200) with a memory and drawer model.
module tb_vector_list_sequencer;
   localparam int OW = 8;
   localparam int AW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            frame_start = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd;
   logic [2*OW+1:0] mem_data = '0;
   logic            busy = 1'b0;
   logic            go;
   logic [OW-1:0]   start_x, start_y, end_x, end_y;
   logic            active, frame_done, frame_overrun;

   vector_list_sequencer #(.OUT_WIDTH(OW), .ADDR_WIDTH(AW), .FRAME_MIN(0), .FRAME_MAX(200)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .busy(busy), .go(go), .start_x(start_x), .start_y(start_y),
      .end_x(end_x), .end_y(end_y), .active(active), .frame_done(frame_done),
      .frame_overrun(frame_overrun));

   always #5 clk = ~clk;

   logic [2*OW+1:0] mem [0:3];
   int checks = 0, errors = 0;
   int go_cnt, done_cnt, ovr_cnt, rd_cnt, rd_zero_cnt, busy_left;
   bit busy_pend, drawer_en = 1'b1;
   int rec_sx [0:7], rec_sy [0:7], rec_ex [0:7], rec_ey [0:7];

   function automatic logic [2*OW+1:0] ent(input logic [1:0] op, input int x, input int y);
      return {op, OW'(x), OW'(y)};
   endfunction

   task automatic clear_stats();
      go_cnt = 0; done_cnt = 0; ovr_cnt = 0; rd_cnt = 0; rd_zero_cnt = 0;
      busy_left = 0; busy_pend = 1'b0; busy = 1'b0; drawer_en = 1'b1;
   endtask

   // One clock: registered memory read, event recording, drawer busy model
   task automatic tick();
      logic rd_prev;
      logic [AW-1:0] a_prev;
      rd_prev = mem_rd;
      a_prev  = mem_addr;
      @(posedge clk); #1;
      if (rd_prev) mem_data = mem[a_prev];
      if (go) begin
         if (go_cnt < 8) begin
            rec_sx[go_cnt] = int'(start_x); rec_sy[go_cnt] = int'(start_y);
            rec_ex[go_cnt] = int'(end_x);   rec_ey[go_cnt] = int'(end_y);
         end
         go_cnt++;
      end
      if (frame_done) done_cnt++;
      if (frame_overrun) ovr_cnt++;
      if (mem_rd) begin
         rd_cnt++;
         if (mem_addr == '0) rd_zero_cnt++;
      end
      if (drawer_en) begin
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy = 1'b0;
         end else if (busy_pend) begin
            busy = 1'b1; busy_left = 4; busy_pend = 1'b0;
         end
         if (go) busy_pend = 1'b1;
      end
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic run_frame(input int max, output bit timed_out);
      int base, n;
      base = done_cnt; n = 0;
      while (done_cnt == base && n < max) begin tick(); n++; end
      timed_out = (done_cnt == base);
   endtask

   task automatic wait_busy(input int max, output bit timed_out);
      int n;
      n = 0;
      while (!busy && n < max) begin tick(); n++; end
      timed_out = !busy;
   endtask

   task automatic test_reset();
      clear_stats();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b want 0", go); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      checks++; if (frame_done !== 1'b0 || frame_overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", frame_done, frame_overrun); end
      checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
      checks++; if (start_x !== 8'd0 || end_y !== 8'd0) begin errors++; $display("FAIL reset_coords: got %0d,%0d want 0,0", start_x, end_y); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_draw_list();
      bit to;
      clear_stats();
      mem[0] = ent(2'b01, 10, 20); mem[1] = ent(2'b10, 50, 60); mem[2] = ent(2'b11, 0, 0); mem[3] = ent(2'b00, 0, 0);
      start_frame();
      checks++; if (active !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 2'd0) begin errors++; $display("FAIL draw_accept: got active=%b rd=%b addr=%0d want 1 1 0", active, mem_rd, mem_addr); end
      tick(); tick();
      checks++; if (go !== 1'b0) begin errors++; $display("FAIL draw_go_early: got %b want 0", go); end
      tick();
      checks++; if (go !== 1'b1) begin errors++; $display("FAIL draw_latency: got go=%b want 1", go); end
      run_frame(100, to);
      checks++; if (to) begin errors++; $display("FAIL draw_timeout: got no frame_done want one"); end
      tick(); tick(); tick();
      checks++; if (go_cnt !== 2) begin errors++; $display("FAIL draw_go_count: got %0d want 2", go_cnt); end
      checks++; if (rec_sx[0] !== 10 || rec_sy[0] !== 20 || rec_ex[0] !== 10 || rec_ey[0] !== 20) begin errors++; $display("FAIL draw_seg1: got (%0d,%0d)-(%0d,%0d) want (10,20)-(10,20)", rec_sx[0], rec_sy[0], rec_ex[0], rec_ey[0]); end
      checks++; if (rec_sx[1] !== 10 || rec_sy[1] !== 20 || rec_ex[1] !== 50 || rec_ey[1] !== 60) begin errors++; $display("FAIL draw_seg2: got (%0d,%0d)-(%0d,%0d) want (10,20)-(50,60)", rec_sx[1], rec_sy[1], rec_ex[1], rec_ey[1]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL draw_done_count: got %0d want 1", done_cnt); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL draw_active_after: got %b want 0", active); end
      checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL draw_no_overrun: got %0d want 0", ovr_cnt); end
   endtask

   task automatic test_nop_list();
      bit to;
      clear_stats();
      mem[0] = ent(2'b00, 1, 1); mem[1] = ent(2'b00, 2, 2); mem[2] = ent(2'b11, 0, 0); mem[3] = ent(2'b01, 9, 9);
      start_frame();
      run_frame(60, to);
      checks++; if (to) begin errors++; $display("FAIL nop_timeout: got no frame_done want one"); end
      checks++; if (mem_addr !== 2'd2) begin errors++; $display("FAIL nop_addr: got %0d want 2", mem_addr); end
      tick(); tick();
      checks++; if (go_cnt !== 0) begin errors++; $display("FAIL nop_go_count: got %0d want 0", go_cnt); end
      checks++; if (done_cnt !== 1 || rd_cnt !== 3) begin errors++; $display("FAIL nop_done_reads: got done=%0d reads=%0d want 1 3", done_cnt, rd_cnt); end
   endtask

   task automatic test_cursor_reset();
      bit to;
      clear_stats();
      mem[0] = ent(2'b10, 30, 40); mem[1] = ent(2'b11, 0, 0);
      start_frame();
      run_frame(60, to);
      checks++; if (to || go_cnt !== 1) begin errors++; $display("FAIL cursor_frame: got timeout=%0d go=%0d want 0 1", to, go_cnt); end
      checks++; if (rec_sx[0] !== 0 || rec_sy[0] !== 0 || rec_ex[0] !== 30 || rec_ey[0] !== 40) begin errors++; $display("FAIL cursor_seg: got (%0d,%0d)-(%0d,%0d) want (0,0)-(30,40)", rec_sx[0], rec_sy[0], rec_ex[0], rec_ey[0]); end
      tick();
   endtask

   task automatic test_overrun();
      bit to;
      int n;
      clear_stats();
      mem[0] = ent(2'b01, 1, 2); mem[1] = ent(2'b10, 3, 4); mem[2] = ent(2'b11, 0, 0);
      start_frame();
      wait_busy(40, to);
      checks++; if (to) begin errors++; $display("FAIL ovr_busy_timeout: got busy=%b want 1", busy); end
      tick();
      start_frame();
      checks++; if (frame_overrun !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL ovr_wait_done: got ovr=%b active=%b want 1 1", frame_overrun, active); end
      n = 0;
      while (!frame_done && n < 80) begin tick(); n++; end
      checks++; if (!frame_done) begin errors++; $display("FAIL ovr_done_timeout: got frame_done=%b want 1", frame_done); end
      start_frame();
      checks++; if (frame_overrun !== 1'b1 || active !== 1'b0) begin errors++; $display("FAIL ovr_done_cycle: got ovr=%b active=%b want 1 0", frame_overrun, active); end
      for (int i = 0; i < 8; i++) tick();
      checks++; if (active !== 1'b0 || go_cnt !== 2 || done_cnt !== 1 || ovr_cnt !== 2) begin errors++; $display("FAIL ovr_totals: got active=%b go=%0d done=%0d ovr=%0d want 0 2 1 2", active, go_cnt, done_cnt, ovr_cnt); end
      checks++; if (rec_sx[1] !== 1 || rec_sy[1] !== 2 || rec_ex[1] !== 3 || rec_ey[1] !== 4) begin errors++; $display("FAIL ovr_seg2: got (%0d,%0d)-(%0d,%0d) want (1,2)-(3,4)", rec_sx[1], rec_sy[1], rec_ex[1], rec_ey[1]); end
   endtask

   task automatic test_addr_end();
      bit to;
      clear_stats();
      for (int i = 0; i < 4; i++) mem[i] = ent(2'b10, i + 1, i + 1);
      start_frame();
      run_frame(120, to);
      checks++; if (to) begin errors++; $display("FAIL end_timeout: got no frame_done want one"); end
      tick(); tick(); tick();
      checks++; if (go_cnt !== 4 || done_cnt !== 1) begin errors++; $display("FAIL end_counts: got go=%0d done=%0d want 4 1", go_cnt, done_cnt); end
      checks++; if (rd_cnt !== 4 || rd_zero_cnt !== 1) begin errors++; $display("FAIL end_no_wrap: got reads=%0d reads_at_0=%0d want 4 1", rd_cnt, rd_zero_cnt); end
      checks++; if (rec_sx[3] !== 3 || rec_sy[3] !== 3 || rec_ex[3] !== 4 || rec_ey[3] !== 4) begin errors++; $display("FAIL end_seg4: got (%0d,%0d)-(%0d,%0d) want (3,3)-(4,4)", rec_sx[3], rec_sy[3], rec_ex[3], rec_ey[3]); end
   endtask

   task automatic test_clamp();
      bit to;
      int exp_x;
`ifdef VECTOR_SEQ_CLAMP_EN
      exp_x = 200;
`else
      exp_x = 250;
`endif
      clear_stats();
      mem[0] = ent(2'b01, 250, 5); mem[1] = ent(2'b11, 0, 0);
      start_frame();
      run_frame(60, to);
      checks++; if (to || go_cnt !== 1) begin errors++; $display("FAIL clamp_frame: got timeout=%0d go=%0d want 0 1", to, go_cnt); end
      checks++; if (rec_ex[0] !== exp_x || rec_ey[0] !== 5) begin errors++; $display("FAIL clamp_end: got (%0d,%0d) want (%0d,5)", rec_ex[0], rec_ey[0], exp_x); end
      tick();
   endtask

   task automatic test_reset_mid_draw();
      bit to;
      clear_stats();
      mem[0] = ent(2'b01, 7, 8); mem[1] = ent(2'b10, 9, 9); mem[2] = ent(2'b11, 0, 0);
      start_frame();
      wait_busy(40, to);
      checks++; if (to) begin errors++; $display("FAIL mid_busy_timeout: got busy=%b want 1", busy); end
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (active !== 1'b0 || go !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 2'd0) begin errors++; $display("FAIL mid_reset_ctrl: got active=%b go=%b rd=%b addr=%0d want 0 0 0 0", active, go, mem_rd, mem_addr); end
      checks++; if (start_x !== 8'd0 || end_x !== 8'd0 || end_y !== 8'd0) begin errors++; $display("FAIL mid_reset_coords: got %0d,%0d,%0d want 0,0,0", start_x, end_x, end_y); end
      drawer_en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         busy = i[0];
         tick();
      end
      checks++; if (go_cnt !== 1 || active !== 1'b0 || done_cnt !== 0) begin errors++; $display("FAIL mid_after_release: got go=%0d active=%b done=%0d want 1 0 0", go_cnt, active, done_cnt); end
      busy = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      test_reset();
      test_draw_list();
      test_nop_list();
      test_cursor_reset();
      test_overrun();
      test_addr_end();
      test_clamp();
      test_reset_mid_draw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
